multi_tone_pwm: RTL and testbench

Parametrised multi-channel tone generator, successor to the single-channel frequency-to-PWM block. Each channel runs a remainder-preserving phase accumulator, so long-term period is exact. Each channel has a programmable duty cycle. Frequency and duty updates are double-buffered and take effect only at a period boundary, so the output never glitches. The block sits between the tone/sequencer control logic and the audio output pins and drives one PWM line per channel plus a mix count.

---
 rtl/multi_tone_pwm_if.sv | 23 ++
 rtl/multi_tone_pwm.sv | 127 ++++++++++++
 tb/tb_multi_tone_pwm.sv | 241 ++++++++++++++++++++++++
 3 files changed

// File: rtl/multi_tone_pwm_if.sv
// Control/output bundle for multi_tone_pwm: shadow-register write port in, PWM lines,
// period ticks and mix count out.
interface multi_tone_pwm_if #(
  parameter int CHANNELS = 4,
  parameter int FREQ_W   = 12,
  parameter int DUTY_W   = 8
);
  localparam int LCH_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam int MIX_W = $clog2(CHANNELS + 1);

  logic                load;
  logic [LCH_W-1:0]    load_ch;
  logic [FREQ_W-1:0]   load_freq;
  logic [DUTY_W-1:0]   load_duty;
  logic [CHANNELS-1:0] pwm;
  logic [CHANNELS-1:0] period_tick;
  logic [MIX_W-1:0]    mix;

  modport master (output load, load_ch, load_freq, load_duty,
                  input  pwm, period_tick, mix);
  modport slave  (input  load, load_ch, load_freq, load_duty,
                  output pwm, period_tick, mix);
endinterface

// File: rtl/multi_tone_pwm.sv
// Multi-channel tone generator: per-channel remainder-preserving phase accumulator with
// double-buffered freq/duty committed only at a period wrap, plus a registered pwm popcount.
module mtp_chan #(
  parameter int FREQ_W = 12,
  parameter int DUTY_W = 8,
  parameter int ACC_W  = 25,
  parameter int CLK_HZ = 25000000
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_load,
  input  logic [FREQ_W-1:0] i_freq,
  input  logic [DUTY_W-1:0] i_duty,
  output logic              o_pwm_nxt,
  output logic              o_pwm,
  output logic              o_tick
);
  localparam int             PROD_W  = ACC_W + DUTY_W;
  localparam logic [ACC_W:0] FULL    = (ACC_W+1)'(CLK_HZ);
  localparam logic [ACC_W-1:0] THR_RST = ACC_W'(CLK_HZ / 2);

  logic [ACC_W-1:0]  r_phase, r_thr;
  logic [FREQ_W-1:0] r_freq, r_sh_freq;
  logic [DUTY_W-1:0] r_sh_duty;
  logic              r_pend;

  logic              w_idle, w_wrap, w_commit, w_mute;
  logic [ACC_W:0]    w_sum;
  logic [FREQ_W-1:0] w_c_freq;
  logic [DUTY_W-1:0] w_c_duty;
  logic [PROD_W-1:0] w_prod;
  logic [ACC_W-1:0]  w_c_thr, w_phase_nxt, w_thr_eff;

  always_comb begin
    w_idle   = (r_freq == '0);
    w_sum    = {1'b0, r_phase} + (ACC_W+1)'(r_freq);
    w_wrap   = !w_idle && (w_sum >= FULL);
    // A load on the wrap cycle bypasses the shadow and commits directly
    w_c_freq = i_load ? i_freq : r_sh_freq;
    w_c_duty = i_load ? i_duty : r_sh_duty;
    w_prod   = PROD_W'(w_c_duty) * PROD_W'(CLK_HZ);
    w_c_thr  = ACC_W'(w_prod >> DUTY_W);
    w_commit = w_idle ? i_load : (w_wrap && (r_pend || i_load));
    w_mute   = w_commit && (w_c_freq == '0);
    if (w_idle || w_mute) w_phase_nxt = '0;
    else if (w_wrap)      w_phase_nxt = ACC_W'(w_sum - FULL);
    else                  w_phase_nxt = ACC_W'(w_sum);
    // The post-wrap phase belongs to the new period, so it uses the committed threshold
    w_thr_eff = (w_commit && !w_idle) ? w_c_thr : r_thr;
    o_pwm_nxt = !w_idle && !w_mute && (w_phase_nxt < w_thr_eff);
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_phase   <= '0;
      r_freq    <= '0;
      r_sh_freq <= '0;
      r_sh_duty <= DUTY_W'(1 << (DUTY_W - 1));
      r_thr     <= THR_RST;
      r_pend    <= 1'b0;
      o_pwm     <= 1'b0;
      o_tick    <= 1'b0;
    end else begin
      r_phase <= w_phase_nxt;
      o_pwm   <= o_pwm_nxt;
      o_tick  <= w_wrap;
      if (i_load) begin
        r_sh_freq <= i_freq;
        r_sh_duty <= i_duty;
      end
      if (w_commit) begin
        r_freq <= w_c_freq;
        r_thr  <= w_c_thr;
        r_pend <= 1'b0;
      end else if (i_load) begin
        r_pend <= 1'b1;
      end
    end
  end
endmodule

module multi_tone_pwm #(
  parameter int CHANNELS = 4,
  parameter int FREQ_W   = 12,
  parameter int DUTY_W   = 8,
  parameter int ACC_W    = 25,
  parameter int CLK_HZ   = 25000000
) (
  input logic              i_clk,
  input logic              i_rst_n,
  multi_tone_pwm_if.slave  bus
);
  localparam int LCH_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam int MIX_W = $clog2(CHANNELS + 1);

  logic [CHANNELS-1:0] w_pwm_nxt, w_pwm, w_tick;
  logic [MIX_W-1:0]    w_pop, r_mix;

  for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
    mtp_chan #(
      .FREQ_W(FREQ_W), .DUTY_W(DUTY_W), .ACC_W(ACC_W), .CLK_HZ(CLK_HZ)
    ) u_ch (
      .i_clk     (i_clk),
      .i_rst_n   (i_rst_n),
      .i_load    (bus.load && (bus.load_ch == LCH_W'(g))),
      .i_freq    (bus.load_freq),
      .i_duty    (bus.load_duty),
      .o_pwm_nxt (w_pwm_nxt[g]),
      .o_pwm     (w_pwm[g]),
      .o_tick    (w_tick[g])
    );
  end

  always_comb begin
    w_pop = '0;
    for (int k = 0; k < CHANNELS; k++) w_pop = w_pop + MIX_W'(w_pwm_nxt[k]);
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_mix <= '0;
    else          r_mix <= w_pop;
  end

  assign bus.pwm         = w_pwm;
  assign bus.period_tick = w_tick;
  assign bus.mix         = r_mix;
endmodule

// File: tb/tb_multi_tone_pwm.sv
// Randomized + directed bench for multi_tone_pwm against an integer tone model (CLK_HZ=1000).
module tb_multi_tone_pwm;
  localparam int CH     = 5;
  localparam int FREQ_W = 12;
  localparam int DUTY_W = 8;
  localparam int ACC_W  = 16;
  localparam int CLK_HZ = 1000;
  localparam int LCH_W  = $clog2(CH);

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  multi_tone_pwm_if #(.CHANNELS(CH), .FREQ_W(FREQ_W), .DUTY_W(DUTY_W)) bus ();
  multi_tone_pwm #(.CHANNELS(CH), .FREQ_W(FREQ_W), .DUTY_W(DUTY_W), .ACC_W(ACC_W),
                   .CLK_HZ(CLK_HZ)) dut (.i_clk(clk), .i_rst_n(rst_n), .bus(bus));

  int n_vec = 0, n_err = 0;
  // model state: one tone per channel, plain integers
  int m_phase[CH], m_freq[CH], m_thr[CH], m_shf[CH], m_shd[CH];
  bit m_pend[CH], e_pwm[CH], e_tick[CH];
  int e_mix;
  // observation tallies for directed checks
  int cnt_tick[CH], cnt_hi[CH], max_mix;

  task automatic chk(input string tag, input int unsigned obs, input int unsigned exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s t=%0t got=%0d want=%0d", tag, $time, obs, exp);
    end
  endtask

  function automatic int thr_of(input int d);
    return (d * CLK_HZ) >> DUTY_W;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < CH; i++) begin
      m_phase[i] = 0; m_freq[i] = 0; m_shf[i] = 0; m_shd[i] = 128;
      m_thr[i] = thr_of(128); m_pend[i] = 0; e_pwm[i] = 0; e_tick[i] = 0;
    end
    e_mix = 0;
  endtask

  task automatic model_step(input bit ld, input int ch, input int f, input int d);
    e_mix = 0;
    for (int i = 0; i < CH; i++) begin
      bit hit, was_active, commit;
      int ph;
      hit = ld && (ch == i);
      was_active = (m_freq[i] != 0);
      commit = 0;
      e_tick[i] = 0;
      if (!was_active) begin
        ph = 0;
        commit = hit;
      end else begin
        ph = m_phase[i] + m_freq[i];
        if (ph >= CLK_HZ) begin
          ph -= CLK_HZ;
          e_tick[i] = 1;
          commit = m_pend[i] || hit;
        end
      end
      if (hit) begin m_shf[i] = f; m_shd[i] = d; end
      if (commit) begin
        m_freq[i] = m_shf[i];
        m_thr[i]  = thr_of(m_shd[i]);
        m_pend[i] = 0;
        if (m_freq[i] == 0) ph = 0;
      end else if (hit) begin
        m_pend[i] = 1;
      end
      m_phase[i] = ph;
      e_pwm[i] = was_active && (m_freq[i] != 0) && (ph < m_thr[i]);
      e_mix += int'(e_pwm[i]);
    end
  endtask

  task automatic clear_tally();
    for (int i = 0; i < CH; i++) begin cnt_tick[i] = 0; cnt_hi[i] = 0; end
    max_mix = 0;
  endtask

  // one clock: drive, edge, advance model, compare everything
  task automatic cyc(input bit ld, input int ch, input int f, input int d);
    int unsigned ep, et;
    bus.load = ld; bus.load_ch = LCH_W'(ch);
    bus.load_freq = FREQ_W'(f); bus.load_duty = DUTY_W'(d);
    @(posedge clk);
    model_step(ld, ch, f, d);
    #1;
    bus.load = 1'b0;
    ep = 0; et = 0;
    for (int i = 0; i < CH; i++) begin
      ep |= 32'(e_pwm[i]) << i;
      et |= 32'(e_tick[i]) << i;
    end
    chk("pwm", 32'(bus.pwm), ep);
    chk("tick", 32'(bus.period_tick), et);
    chk("mix", 32'(bus.mix), 32'(e_mix));
    for (int i = 0; i < CH; i++) begin
      cnt_tick[i] += int'(bus.period_tick[i]);
      cnt_hi[i]   += int'(bus.pwm[i]);
    end
    if (int'(bus.mix) > max_mix) max_mix = int'(bus.mix);
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) cyc(0, 0, 0, 0);
  endtask

  task automatic wait_tick(input int ch, input int maxc, output int n);
    n = 0;
    do begin
      cyc(0, 0, 0, 0);
      n++;
    end while (!bus.period_tick[ch] && n < maxc);
    chk("tick_seen", 32'(bus.period_tick[ch]), 1);
  endtask

  task automatic reset_midrun();
    #3 rst_n = 1'b0;
    #1;
    chk("rst_pwm", 32'(bus.pwm), 0);
    chk("rst_tick", 32'(bus.period_tick), 0);
    chk("rst_mix", 32'(bus.mix), 0);
    model_reset();
    @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  initial begin
    int n, gsum, gmin, gmax;
    bus.load = 0; bus.load_ch = '0; bus.load_freq = '0; bus.load_duty = '0;
    model_reset();
    clear_tally();
    #1 rst_n = 1'b0;
    #1;
    chk("por_pwm", 32'(bus.pwm), 0);
    chk("por_mix", 32'(bus.mix), 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    idle(20);
    chk("idle_ticks", 32'(cnt_tick[0] + cnt_tick[1] + cnt_tick[4]), 0);

    // basic tone: 100 Hz at 1 kHz clock, 50% duty
    cyc(1, 0, 100, 128);
    clear_tally();
    idle(100);
    chk("basic_ticks", 32'(cnt_tick[0]), 10);
    chk("basic_high", 32'(cnt_hi[0]), 50);

    // remainder: 300 Hz -> gaps 3/3/4, 300 ticks in exactly 1000 cycles
    cyc(1, 1, 300, 128);
    gsum = 0; gmin = 1000; gmax = 0;
    for (int k = 0; k < 300; k++) begin
      wait_tick(1, 10, n);
      gsum += n;
      if (n < gmin) gmin = n;
      if (n > gmax) gmax = n;
    end
    chk("rem_total", 32'(gsum), 1000);
    chk("rem_gmin", 32'(gmin), 3);
    chk("rem_gmax", 32'(gmax), 4);

    // glitch-free update mid-period
    wait_tick(0, 20, n);
    idle(3);
    cyc(1, 0, 200, 64);
    wait_tick(0, 20, n);
    chk("gf_old_period", 32'(n), 6);
    clear_tally();
    idle(10);
    chk("gf_new_ticks", 32'(cnt_tick[0]), 2);
    chk("gf_new_high", 32'(cnt_hi[0]), 4);

    // load coincident with wrap commits at that wrap
    wait_tick(0, 20, n);
    idle(4);
    cyc(1, 0, 250, 128);
    chk("coin_tick", 32'(bus.period_tick[0]), 1);
    wait_tick(0, 20, n);
    chk("coin_period", 32'(n), 4);

    // out-of-range channel loads are ignored
    clear_tally();
    cyc(1, 5, 100, 128);
    cyc(1, 6, 200, 200);
    cyc(1, 7, 300, 255);
    idle(20);
    chk("ign_ticks", 32'(cnt_tick[2] + cnt_tick[3] + cnt_tick[4]), 0);
    chk("ign_ch0", 32'(cnt_tick[0]), 23 / 4);

    // two loads before a wrap: last wins
    wait_tick(0, 20, n);
    cyc(1, 0, 100, 128);
    cyc(1, 0, 500, 128);
    wait_tick(0, 20, n);
    chk("lw_commit", 32'(n), 2);
    wait_tick(0, 20, n);
    chk("lw_period", 32'(n), 2);

    // multi-channel, then mute ch2
    cyc(1, 0, 100, 255);
    cyc(1, 1, 130, 255);
    cyc(1, 2, 170, 255);
    cyc(1, 3, 230, 255);
    clear_tally();
    idle(100);
    chk("multi_mix_max", 32'(max_mix), 4);
    cyc(1, 2, 0, 255);
    wait_tick(2, 20, n);
    clear_tally();
    idle(200);
    chk("mute_ticks", 32'(cnt_tick[2]), 0);
    chk("mute_high", 32'(cnt_hi[2]), 0);
    chk("mute_mix_max", 32'(max_mix), 3);

    reset_midrun();
    clear_tally();
    idle(20);
    chk("post_rst_ticks", 32'(cnt_tick[0] + cnt_tick[1] + cnt_tick[3]), 0);

    // randomized traffic
    for (int k = 0; k < 3000; k++) begin
      bit ld;
      int ch, f, d;
      ld = ($urandom_range(7) == 0);
      ch = int'($urandom_range(7));
      f  = ($urandom_range(9) == 0) ? 0 : int'($urandom_range(499, 1));
      d  = int'($urandom_range(255));
      if (k == 1500) reset_midrun();
      cyc(ld, ch, f, d);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
